tron_round_ctrl: RTL
====================

Name: tron_round_ctrl

Overview:
- Game-round sequencer for the two-player light-cycle game. Sits between the debounced buttons, the periodic system tick, the collision decider's gameover code and the trail-map clear logic.
- Runs each round through four phases: clear the arena, count down, play, then hold on the crash result.
- Gates both PicoBlaze players through play_en, keeps the match score and declares the match winner.

Parameters:
- COUNT_START, 3, countdown start value shown before play begins (1..15).
- TICKS_PER_STEP, 50, number of tick pulses per countdown decrement (1..255).
- HOLD_TICKS, 100, number of tick pulses the crash result is held before the next round (1..255).
- WIN_SCORE, 5, score that ends the match (1..15).
- MAX_ROUND_TICKS, 3000, round length limit in ticks, used only when ROUND_TIMEOUT_EN is defined (16-bit).

Ports:
- clk  in  1  100 MHz system clock
- reset  in  1  asynchronous, active-low reset
- tick  in  1  single-cycle pulse from the interrupt generator
- start  in  1  debounced centre button, level; rising edge detected internally
- gameover  in  2  decider code: 0 running, 1 P1 crashed, 2 P2 crashed, 3 both crashed
- clr_done  in  1  single-cycle pulse from the trail-map clear engine
- clr_req  out  1  request to clear the trail map; held until clr_done
- play_en  out  1  enables player movement and interrupts
- p1_score  out  4  player 1 rounds won
- p2_score  out  4  player 2 rounds won
- countdown  out  4  countdown digit shown on the seven-segment display
- round_result  out  2  last round: 0 none, 1 P1 won, 2 P2 won, 3 draw
- winner  out  2  match winner: 0 none, 1 P1, 2 P2
- state  out  3  current FSM state encoding, for debug LEDs

Behaviour:
- Reset (async, active-low): state=IDLE; all outputs 0; edge-detect register, tick counter and round timer cleared. Reset mid-round drops clr_req and play_en immediately, with no wait for a clock edge.
- State encoding: IDLE=0, CLEAR=1, COUNT=2, PLAY=3, HOLD=4, MATCH=5. All outputs are registered.
- Start edge: start_q is registered each cycle; an edge is start & ~start_q. An edge is acted on only in IDLE and MATCH and is ignored in all other states.
- IDLE -> CLEAR on a start edge:
  - Clear p1_score, p2_score, winner and round_result.
  - Assert clr_req on the next cycle.
- CLEAR:
  - clr_req=1. When clr_done=1 is sampled, go to COUNT.
  - On that transition: clr_req=0, countdown=COUNT_START, tick counter=0.
  - clr_done in any other state is ignored.
- COUNT:
  - Each tick increments the tick counter. When the counter reaches TICKS_PER_STEP, it resets to 0 and countdown decrements.
  - The decrement from 1 to 0 moves the FSM to PLAY. play_en=1 from the first PLAY cycle.
- PLAY:
  - gameover is sampled every cycle. A nonzero value latches round_result and updates scores in the same edge:
    - 1 -> p2_score+1, round_result=2
    - 2 -> p1_score+1, round_result=1
    - 3 -> no score change, round_result=3
  - On that edge play_en=0 and the FSM goes to HOLD.
  - Scores saturate at 15.
- HOLD: counts HOLD_TICKS ticks. At expiry:
  - if p1_score>=WIN_SCORE, winner=1 and go to MATCH;
  - else if p2_score>=WIN_SCORE, winner=2 and go to MATCH;
  - else go to CLEAR (clr_req=1 next cycle).
- MATCH:
  - Outputs hold steady. A start edge behaves exactly as in IDLE: scores and winner are cleared and the FSM goes to CLEAR.
- Tick counter: reset to 0 on every state entry. A tick arriving in the entry cycle is not counted.

Optional Feature:
- Macro: ROUND_TIMEOUT_EN.
- Defined:
  - A 16-bit round timer clears on PLAY entry and increments on each tick in PLAY.
  - When it reaches MAX_ROUND_TICKS with gameover=0, the round ends as a draw: round_result=3, no score change, go to HOLD.
  - A nonzero gameover in that same cycle takes priority over the timeout.
- Undefined: no timer logic is built; a round ends only on a nonzero gameover.

Test Plan:
- Nominal round: reset, start edge, clr_done 3 cycles later -> clr_req high exactly 3 cycles; countdown steps 3,2,1 every 50 ticks; play_en=1 after the 150th tick.
- Scoring: in PLAY drive gameover=2 -> p1_score=1, round_result=1, play_en=0 on the same edge; after 100 ticks -> state=CLEAR, clr_req=1.
- Match end and saturation: after five P2 wins -> p2_score=5, winner=2, state=MATCH. Extra start glitches held high produce no action until a new rising edge. The new edge clears scores and winner.
- Draw and ignored inputs: gameover=3 -> scores unchanged, round_result=3. A start edge in PLAY and a clr_done pulse in COUNT cause no state change.
- Async reset: assert reset mid-CLEAR with no clock edge -> clr_req, play_en and state read 0 immediately; after release the FSM stays in IDLE.
- ROUND_TIMEOUT_EN with MAX_ROUND_TICKS=20:
  - gameover=0 for 20 PLAY ticks -> round_result=3, state=HOLD.
  - gameover=1 on the 20th tick -> p2_score+1 instead of a draw.

Source files
------------

// File: rtl/tron_round_ctrl_if.sv
// rtl/tron_round_ctrl_if.sv - round sequencer bus: game inputs in, round status out
interface tron_round_ctrl_if;
  logic       tick;
  logic       start;
  logic [1:0] gameover;
  logic       clr_done;
  logic       clr_req;
  logic       play_en;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [3:0] countdown;
  logic [1:0] round_result;
  logic [1:0] winner;
  logic [2:0] state;

  modport master (
    output tick, start, gameover, clr_done,
    input  clr_req, play_en, p1_score, p2_score, countdown, round_result, winner, state
  );

  modport slave (
    input  tick, start, gameover, clr_done,
    output clr_req, play_en, p1_score, p2_score, countdown, round_result, winner, state
  );
endinterface

// File: rtl/tron_round_ctrl.sv
// rtl/tron_round_ctrl.sv - light-cycle round sequencer: clear, countdown, play, hold, match
// Optional round time limit enabled by defining ROUND_TIMEOUT_EN.
module tron_round_ctrl #(
  parameter int unsigned COUNT_START     = 3,
  parameter int unsigned TICKS_PER_STEP  = 50,
  parameter int unsigned HOLD_TICKS      = 100,
  parameter int unsigned WIN_SCORE       = 5
`ifdef ROUND_TIMEOUT_EN
  ,
  parameter int unsigned MAX_ROUND_TICKS = 3000
`endif
) (
  input logic              clk,
  input logic              reset,
  tron_round_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_COUNT = 3'd2,
    S_PLAY  = 3'd3,
    S_HOLD  = 3'd4,
    S_MATCH = 3'd5
  } state_t;

  localparam logic [3:0] L_CS   = 4'(COUNT_START);
  localparam logic [7:0] L_TPS  = 8'(TICKS_PER_STEP);
  localparam logic [7:0] L_HOLD = 8'(HOLD_TICKS);
  localparam logic [3:0] L_WIN  = 4'(WIN_SCORE);

  state_t     r_state, w_state_nxt;
  logic       r_start_q;
  logic [7:0] r_tick_cnt, w_tick_cnt_nxt;
  logic       r_clr_req, w_clr_req_nxt;
  logic       r_play_en, w_play_en_nxt;
  logic [3:0] r_p1, w_p1_nxt;
  logic [3:0] r_p2, w_p2_nxt;
  logic [3:0] r_countdown, w_countdown_nxt;
  logic [1:0] r_rr, w_rr_nxt;
  logic [1:0] r_winner, w_winner_nxt;
  logic       w_start_edge;
  logic [7:0] w_tick_inc;
`ifdef ROUND_TIMEOUT_EN
  localparam logic [15:0] L_MAX = 16'(MAX_ROUND_TICKS);
  logic [15:0] r_round_timer, w_round_timer_nxt;
`endif

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'd15) ? v : v + 4'd1;
  endfunction

  assign w_start_edge = bus.start & ~r_start_q;
  assign w_tick_inc   = r_tick_cnt + 8'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_start_q   <= 1'b0;
      r_tick_cnt  <= '0;
      r_clr_req   <= 1'b0;
      r_play_en   <= 1'b0;
      r_p1        <= '0;
      r_p2        <= '0;
      r_countdown <= '0;
      r_rr        <= '0;
      r_winner    <= '0;
`ifdef ROUND_TIMEOUT_EN
      r_round_timer <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_start_q   <= bus.start;
      r_tick_cnt  <= w_tick_cnt_nxt;
      r_clr_req   <= w_clr_req_nxt;
      r_play_en   <= w_play_en_nxt;
      r_p1        <= w_p1_nxt;
      r_p2        <= w_p2_nxt;
      r_countdown <= w_countdown_nxt;
      r_rr        <= w_rr_nxt;
      r_winner    <= w_winner_nxt;
`ifdef ROUND_TIMEOUT_EN
      r_round_timer <= w_round_timer_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_tick_cnt_nxt  = r_tick_cnt;
    w_clr_req_nxt   = r_clr_req;
    w_play_en_nxt   = r_play_en;
    w_p1_nxt        = r_p1;
    w_p2_nxt        = r_p2;
    w_countdown_nxt = r_countdown;
    w_rr_nxt        = r_rr;
    w_winner_nxt    = r_winner;
`ifdef ROUND_TIMEOUT_EN
    w_round_timer_nxt = r_round_timer;
`endif
    case (r_state)
      S_IDLE, S_MATCH: begin
        if (w_start_edge) begin
          w_p1_nxt      = '0;
          w_p2_nxt      = '0;
          w_winner_nxt  = '0;
          w_rr_nxt      = '0;
          w_clr_req_nxt = 1'b1;
          w_state_nxt   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (bus.clr_done) begin
          w_clr_req_nxt   = 1'b0;
          w_countdown_nxt = L_CS;
          w_state_nxt     = S_COUNT;
        end
      end
      S_COUNT: begin
        if (bus.tick) begin
          if (w_tick_inc == L_TPS) begin
            w_tick_cnt_nxt  = '0;
            w_countdown_nxt = r_countdown - 4'd1;
            if (r_countdown == 4'd1) begin
              w_play_en_nxt = 1'b1;
              w_state_nxt   = S_PLAY;
            end
          end else begin
            w_tick_cnt_nxt = w_tick_inc;
          end
        end
      end
      S_PLAY: begin
        // A crash code always wins over the time limit in the same cycle.
        if (bus.gameover != 2'd0) begin
          w_play_en_nxt = 1'b0;
          w_state_nxt   = S_HOLD;
          case (bus.gameover)
            2'd1: begin
              w_p2_nxt = sat_inc(r_p2);
              w_rr_nxt = 2'd2;
            end
            2'd2: begin
              w_p1_nxt = sat_inc(r_p1);
              w_rr_nxt = 2'd1;
            end
            default: w_rr_nxt = 2'd3;
          endcase
        end
`ifdef ROUND_TIMEOUT_EN
        else if (bus.tick && (r_round_timer == L_MAX - 16'd1)) begin
          w_rr_nxt      = 2'd3;
          w_play_en_nxt = 1'b0;
          w_state_nxt   = S_HOLD;
        end else if (bus.tick) begin
          w_round_timer_nxt = r_round_timer + 16'd1;
        end
`endif
      end
      S_HOLD: begin
        if (bus.tick) begin
          if (w_tick_inc == L_HOLD) begin
            if (r_p1 >= L_WIN) begin
              w_winner_nxt = 2'd1;
              w_state_nxt  = S_MATCH;
            end else if (r_p2 >= L_WIN) begin
              w_winner_nxt = 2'd2;
              w_state_nxt  = S_MATCH;
            end else begin
              w_clr_req_nxt = 1'b1;
              w_state_nxt   = S_CLEAR;
            end
          end else begin
            w_tick_cnt_nxt = w_tick_inc;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Every state starts its tick count from zero; a tick on the entry edge is dropped.
    if (w_state_nxt != r_state) w_tick_cnt_nxt = '0;
`ifdef ROUND_TIMEOUT_EN
    if ((w_state_nxt == S_PLAY) && (r_state != S_PLAY)) w_round_timer_nxt = '0;
`endif
  end

  assign bus.clr_req      = r_clr_req;
  assign bus.play_en      = r_play_en;
  assign bus.p1_score     = r_p1;
  assign bus.p2_score     = r_p2;
  assign bus.countdown    = r_countdown;
  assign bus.round_result = r_rr;
  assign bus.winner       = r_winner;
  assign bus.state        = r_state;

endmodule
